// File: rtl/alu_txn_driver.sv
// -----------------------------------------------------------------------------
// alu_txn_driver
//
// Sequential front end for a 4-bit combinational ALU. Commands arrive on a
// valid/ready port and are registered onto the ALU operand outputs. After a
// programmable settle interval the ALU result is sampled, compared against a
// locally computed expected value, and returned on a valid/ready response
// port. Completed responses and miscompares are counted with saturation.
//
// Parameters
//   SETTLE_CYCLES  cycles between driving the ALU and sampling its result (1..15)
//   CNT_W          width of txn_count / err_count
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   cmd_valid     command present
//   cmd_ready     command accepted (IDLE only, low while rst=1)
//   cmd_a/cmd_b   4-bit operands
//   cmd_op        000 ADD, 001 SUB, 010 AND, 011 OR, 1xx NOP
//   alu_a/alu_b   registered operands to the ALU
//   alu_op_code   registered op code to the ALU
//   alu_result    ALU result input
//   rsp_valid     response present
//   rsp_ready     consumer accepts response
//   rsp_result    sampled ALU result
//   rsp_err       1 when rsp_result differs from the expected value
//   txn_count     completed responses, saturating
//   err_count     completed responses with rsp_err=1, saturating
// -----------------------------------------------------------------------------
module alu_txn_driver #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op_code,
    input  logic [3:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    // Counter reload value: the capture edge is SETTLE_CYCLES edges after accept,
    // and the accept edge itself loads the counter.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Reference model of the ALU. All arithmetic wraps mod 16; every op code
    // with the top bit set is a NOP that yields zero.
    function automatic logic [3:0] expected_result(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [2:0] op
    );
        logic [3:0] r;
        unique case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q,      state_d;
    logic [3:0]        settle_q,     settle_d;
    logic [3:0]        exp_q,        exp_d;
    logic [3:0]        alu_a_q,      alu_a_d;
    logic [3:0]        alu_b_q,      alu_b_d;
    logic [2:0]        alu_op_q,     alu_op_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic [3:0]        rsp_result_q, rsp_result_d;
    logic              rsp_err_q,    rsp_err_d;
    logic [CNT_W-1:0]  txn_count_q,  txn_count_d;
    logic [CNT_W-1:0]  err_count_q,  err_count_d;

    logic cmd_accept;
    logic rsp_fire;

    // cmd_ready is gated with rst so no command can be accepted during reset,
    // not even on the very first cycle before the state register settles.
    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign rsp_fire   = rsp_valid_q && rsp_ready;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a missed
        // assignment on any path would otherwise infer a latch.
        state_d      = state_q;
        settle_d     = settle_q;
        exp_d        = exp_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        txn_count_d  = txn_count_q;
        err_count_d  = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    // ALU operands only change here, so the ALU sees stable
                    // inputs for the whole settle interval.
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    exp_d    = expected_result(cmd_a, cmd_b, cmd_op);
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (settle_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = (alu_result != exp_q);
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            ST_RESP: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    if (txn_count_q != '1) begin
                        txn_count_d = txn_count_q + 1'b1;
                    end
                    if (rsp_err_q && (err_count_q != '1)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    // Returning to IDLE rather than accepting here means
                    // cmd_ready rises only the cycle after the handshake.
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only in clocked blocks, so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_q     <= 4'd0;
            exp_q        <= 4'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_op_q     <= 3'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_err_q    <= 1'b0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            exp_q        <= exp_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op_code = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign txn_count   = txn_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_txn_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_txn_driver
//
// Directed bench for alu_txn_driver. Two instances: u_dut0 with the default
// parameters (SETTLE_CYCLES=1, CNT_W=8) and u_dut1 with SETTLE_CYCLES=4,
// CNT_W=2. A behavioural ALU closes the loop on each instance; u_dut0's ALU
// result can be overridden to provoke a miscompare. Shared stimulus is routed
// to whichever instance `sel` picks; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_alu_txn_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       cmd_valid;
    logic       rsp_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       force_en;
    logic [3:0] force_val;

    int n_vec = 0;
    int n_bad = 0;

    // Instance 0 wiring
    logic       cmd_ready0, rsp_valid0, rsp_err0;
    logic [3:0] alu_a0, alu_b0, alu_result0, rsp_result0;
    logic [2:0] alu_op0;
    logic [7:0] txn0, err0;

    // Instance 1 wiring
    logic       cmd_ready1, rsp_valid1, rsp_err1;
    logic [3:0] alu_a1, alu_b1, alu_result1, rsp_result1;
    logic [2:0] alu_op1;
    logic [1:0] txn1, err1;

    // Behavioural stand-in for the external combinational ALU.
    function automatic logic [3:0] alu_beh(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 4'b0000;
        endcase
    endfunction

    assign alu_result0 = force_en ? force_val : alu_beh(alu_a0, alu_b0, alu_op0);
    assign alu_result1 = alu_beh(alu_a1, alu_b1, alu_op1);

    alu_txn_driver u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid && !sel),
        .cmd_ready   (cmd_ready0),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a0),
        .alu_b       (alu_b0),
        .alu_op_code (alu_op0),
        .alu_result  (alu_result0),
        .rsp_valid   (rsp_valid0),
        .rsp_ready   (rsp_ready && !sel),
        .rsp_result  (rsp_result0),
        .rsp_err     (rsp_err0),
        .txn_count   (txn0),
        .err_count   (err0)
    );

    alu_txn_driver #(.SETTLE_CYCLES(4), .CNT_W(2)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid && sel),
        .cmd_ready   (cmd_ready1),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a1),
        .alu_b       (alu_b1),
        .alu_op_code (alu_op1),
        .alu_result  (alu_result1),
        .rsp_valid   (rsp_valid1),
        .rsp_ready   (rsp_ready && sel),
        .rsp_result  (rsp_result1),
        .rsp_err     (rsp_err1),
        .txn_count   (txn1),
        .err_count   (err1)
    );

    // Observed outputs of the selected instance.
    logic       s_cmd_ready, s_rsp_valid, s_rsp_err;
    logic [3:0] s_rsp_result, s_alu_a;
    logic [7:0] s_txn, s_err;

    assign s_cmd_ready  = sel ? cmd_ready1  : cmd_ready0;
    assign s_rsp_valid  = sel ? rsp_valid1  : rsp_valid0;
    assign s_rsp_err    = sel ? rsp_err1    : rsp_err0;
    assign s_rsp_result = sel ? rsp_result1 : rsp_result0;
    assign s_alu_a      = sel ? alu_a1      : alu_a0;
    assign s_txn        = sel ? {6'd0, txn1} : txn0;
    assign s_err        = sel ? {6'd0, err1} : err0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, then wait (bounded) for the response and check latency.
    task automatic send_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input int settle);
        int n;
        check({tag, " cmd_ready before accept"}, 32'(s_cmd_ready), 32'd1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, " cmd_ready in WAIT"}, 32'(s_cmd_ready), 32'd0);
        check({tag, " alu_a registered"}, 32'(s_alu_a), 32'(a));
        n = 0;
        while (!s_rsp_valid && n < 32) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(settle));
    endtask

    // Check the held response, then complete the handshake.
    task automatic collect(input string tag, input logic [3:0] exp_res, input logic exp_err);
        check({tag, " rsp_result"}, 32'(s_rsp_result), 32'(exp_res));
        check({tag, " rsp_err"}, 32'(s_rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after handshake"}, 32'(s_rsp_valid), 32'd0);
        check({tag, " cmd_ready after handshake"}, 32'(s_cmd_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] exp_res, input logic exp_err,
                       input int settle);
        send_cmd(tag, a, b, op, settle);
        collect(tag, exp_res, exp_err);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_op    = 3'h0;
        force_en  = 1'b0;
        force_val = 4'h0;

        // Reset state of both instances
        tick();
        tick();
        check("rst cmd_ready0", 32'(cmd_ready0), 32'd0);
        check("rst rsp_valid0", 32'(rsp_valid0), 32'd0);
        check("rst outputs0", {8'(alu_a0), 8'(rsp_result0), txn0, err0}, 32'd0);
        check("rst cmd_ready1", 32'(cmd_ready1), 32'd0);
        check("rst outputs1", {alu_a1, rsp_result1, txn1, err1, rsp_valid1, rsp_err1}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle cmd_ready0", 32'(cmd_ready0), 32'd1);

        // 1-2: every op on 0011 / 0101
        txn("add", 4'h3, 4'h5, 3'b000, 4'h8, 1'b0, 1);
        txn("sub", 4'h3, 4'h5, 3'b001, 4'hE, 1'b0, 1);
        txn("and", 4'h3, 4'h5, 3'b010, 4'h1, 1'b0, 1);
        txn("or",  4'h3, 4'h5, 3'b011, 4'h7, 1'b0, 1);
        txn("nop", 4'h3, 4'h5, 3'b100, 4'h0, 1'b0, 1);
        check("txn_count after 5", 32'(s_txn), 32'd5);
        check("err_count after 5", 32'(s_err), 32'd0);

        // 3: wrap-around
        txn("add wrap", 4'hF, 4'h1, 3'b000, 4'h0, 1'b0, 1);
        txn("sub wrap", 4'h0, 4'h1, 3'b001, 4'hF, 1'b0, 1);
        check("txn_count after wrap", 32'(s_txn), 32'd7);

        // 4: backpressure; new cmd_* while busy must be ignored
        send_cmd("bp", 4'h3, 4'h5, 3'b000, 1);
        cmd_a     = 4'hC;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp rsp_valid held", 32'(s_rsp_valid), 32'd1);
            check("bp rsp_result held", 32'(s_rsp_result), 32'h8);
            check("bp cmd_ready low", 32'(s_cmd_ready), 32'd0);
            check("bp txn_count", 32'(s_txn), 32'd7);
        end
        check("bp alu_a stable", 32'(s_alu_a), 32'h3);
        cmd_valid = 1'b0;
        collect("bp", 4'h8, 1'b0);
        check("txn_count after bp", 32'(s_txn), 32'd8);

        // 5: forced ALU miscompare, then reset in WAIT
        force_en  = 1'b1;
        force_val = 4'hA;
        txn("forced", 4'h3, 4'h5, 3'b000, 4'hA, 1'b1, 1);
        force_en  = 1'b0;
        check("err_count forced", 32'(s_err), 32'd1);
        check("txn_count forced", 32'(s_txn), 32'd9);

        cmd_a     = 4'h6;
        cmd_b     = 4'h2;
        cmd_op    = 3'b000;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("pre-rst in WAIT", 32'(s_cmd_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("mid rst rsp_valid", 32'(s_rsp_valid), 32'd0);
        check("mid rst cmd_ready", 32'(s_cmd_ready), 32'd0);
        check("mid rst regs", {8'(alu_a0), 8'(rsp_result0), txn0, err0}, 32'd0);
        rst = 1'b0;
        tick();
        check("post rst cmd_ready", 32'(s_cmd_ready), 32'd1);

        // 6: SETTLE_CYCLES=4, CNT_W=2, saturation at 2'b11
        sel = 1'b1;
        tick();
        txn("s4 t1", 4'h1, 4'h2, 3'b000, 4'h3, 1'b0, 4);
        check("s4 txn1", 32'(s_txn), 32'd1);
        txn("s4 t2", 4'h2, 4'h3, 3'b001, 4'hF, 1'b0, 4);
        check("s4 txn2", 32'(s_txn), 32'd2);
        txn("s4 t3", 4'hC, 4'hA, 3'b010, 4'h8, 1'b0, 4);
        check("s4 txn3", 32'(s_txn), 32'd3);
        txn("s4 t4", 4'h9, 4'h4, 3'b011, 4'hD, 1'b0, 4);
        check("s4 txn4 sat", 32'(s_txn), 32'd3);
        txn("s4 t5", 4'h7, 4'h7, 3'b111, 4'h0, 1'b0, 4);
        check("s4 txn5 sat", 32'(s_txn), 32'd3);
        check("s4 err_count", 32'(s_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
